// File: rtl/ctrl_cfg_pkt_gen.sv
// ---------------------------------------------------------------------------
// ctrl_cfg_pkt_gen
//
// Builds the 256-bit AXI-Stream configuration packets used by the RMT stage
// key-extract units.  A single write request becomes one of two packets:
//   - key-offset entry (req_type = 0): 3 beats, 96 bytes
//   - key-mask entry   (req_type = 1): 4 beats, 128 bytes
// Beat 0 carries a constant outer header.  Beat 1 is the control beat that
// carries the module ID, table type, sub-unit and index.  The remaining beats
// carry the entry payload in byte-reversed order.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake; fields are latched on acceptance
//   req_stage         : target stage ID   (mod_id[7:3])
//   req_unit          : target unit ID    (mod_id[2:0])
//   req_sub_unit      : target sub-unit ID
//   req_type          : 0 = key-offset entry, 1 = key-mask entry
//   req_index         : table index
//   req_data          : entry payload (offset uses the low KEY_OFF bits)
//   c_m_axis_*        : configuration stream master (all outputs registered)
//   pkt_done          : one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module ctrl_cfg_pkt_gen #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int KEY_LEN              = 257,
    parameter int KEY_OFF              = 68,
    parameter logic [C_S_AXIS_DATA_WIDTH-1:0] HDR_BEAT0 = '0
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [4:0]                        req_stage,
    input  logic [2:0]                        req_unit,
    input  logic [3:0]                        req_sub_unit,
    input  logic                              req_type,
    input  logic [7:0]                        req_index,
    input  logic [KEY_LEN-1:0]                req_data,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    input  logic                              c_m_axis_tready,
    output logic                              c_m_axis_tlast,

    output logic                              pkt_done
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int TW = C_S_AXIS_TUSER_WIDTH;
    localparam int NB = DW / 8;

    // Packet byte lengths reported in tuser[15:0].
    localparam logic [15:0] LEN_OFFSET = 16'd96;
    localparam logic [15:0] LEN_MASK   = 16'd128;

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        B3
    } state_t;

    state_t state_reg;

    // Request fields captured at acceptance; the packet in flight is built
    // only from these, never from the live request inputs.
    logic [4:0]         stage_reg;
    logic [2:0]         unit_reg;
    logic [3:0]         sub_unit_reg;
    logic               type_reg;
    logic [7:0]         index_reg;
    logic [KEY_LEN-1:0] data_reg;

    // -----------------------------------------------------------------------
    // Payload beats, built combinationally from the latched request.
    // The *_src vectors hold the payload in "natural" order (most
    // significant byte first in the packet); the beat is its byte reversal.
    // -----------------------------------------------------------------------
    logic [DW-1:0] off_src;
    logic [DW-1:0] mask_hi_src;
    logic [DW-1:0] mask_lo_src;
    logic [DW-1:0] off_beat;
    logic [DW-1:0] mask_hi_beat;
    logic [DW-1:0] mask_lo_beat;
    logic [DW-1:0] ctrl_beat;

    // Offset entry sits in the top KEY_OFF bits of the source word.
    assign off_src     = {data_reg[KEY_OFF-1:0], {(DW-KEY_OFF){1'b0}}};
    // Mask entry is one bit wider than a beat: the upper 256 bits go in the
    // first payload beat, the leftover LSB becomes the MSB of the next one.
    assign mask_hi_src = data_reg[KEY_LEN-1:1];
    assign mask_lo_src = {data_reg[0], {(DW-1){1'b0}}};

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bswap
            assign off_beat[8*gi +: 8]     = off_src[DW-8-8*gi +: 8];
            assign mask_hi_beat[8*gi +: 8] = mask_hi_src[DW-8-8*gi +: 8];
            assign mask_lo_beat[8*gi +: 8] = mask_lo_src[DW-8-8*gi +: 8];
        end
    endgenerate

    // Control beat: magic F2F1 followed by module ID, type, sub-unit, index.
    always_comb begin
        ctrl_beat            = '0;
        ctrl_beat[79:64]     = 16'hF2F1;
        ctrl_beat[119:112]   = {stage_reg, unit_reg};
        ctrl_beat[123:120]   = {3'b000, type_reg};
        ctrl_beat[127:124]   = sub_unit_reg;
        ctrl_beat[135:128]   = index_reg;
    end

    logic beat_accept;
    assign beat_accept = c_m_axis_tvalid && c_m_axis_tready;

    // -----------------------------------------------------------------------
    // Packet sequencer.  Every output is registered: on each accepted beat
    // the registers are loaded with the *next* beat, so the stream never
    // drops tvalid between beats when tready stays high.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            req_ready       <= 1'b1;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tlast  <= 1'b0;
            pkt_done        <= 1'b0;
            stage_reg       <= '0;
            unit_reg        <= '0;
            sub_unit_reg    <= '0;
            type_reg        <= 1'b0;
            index_reg       <= '0;
            data_reg        <= '0;
        end else begin
            pkt_done <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        stage_reg       <= req_stage;
                        unit_reg        <= req_unit;
                        sub_unit_reg    <= req_sub_unit;
                        type_reg        <= req_type;
                        index_reg       <= req_index;
                        data_reg        <= req_data;

                        state_reg       <= B0;
                        req_ready       <= 1'b0;
                        c_m_axis_tvalid <= 1'b1;
                        c_m_axis_tdata  <= HDR_BEAT0;
                        c_m_axis_tuser  <= {{(TW-16){1'b0}},
                                            req_type ? LEN_MASK : LEN_OFFSET};
                        c_m_axis_tkeep  <= '1;
                        c_m_axis_tlast  <= 1'b0;
                    end
                end

                B0: begin
                    if (beat_accept) begin
                        state_reg      <= B1;
                        c_m_axis_tdata <= ctrl_beat;
                    end
                end

                B1: begin
                    if (beat_accept) begin
                        state_reg      <= B2;
                        c_m_axis_tdata <= type_reg ? mask_hi_beat : off_beat;
                        // Offset packets end on the first payload beat.
                        c_m_axis_tlast <= !type_reg;
                    end
                end

                B2: begin
                    if (beat_accept) begin
                        if (type_reg) begin
                            state_reg      <= B3;
                            c_m_axis_tdata <= mask_lo_beat;
                            c_m_axis_tlast <= 1'b1;
                        end else begin
                            state_reg       <= IDLE;
                            req_ready       <= 1'b1;
                            c_m_axis_tvalid <= 1'b0;
                            c_m_axis_tdata  <= '0;
                            c_m_axis_tuser  <= '0;
                            c_m_axis_tkeep  <= '0;
                            c_m_axis_tlast  <= 1'b0;
                            pkt_done        <= 1'b1;
                        end
                    end
                end

                B3: begin
                    if (beat_accept) begin
                        state_reg       <= IDLE;
                        req_ready       <= 1'b1;
                        c_m_axis_tvalid <= 1'b0;
                        c_m_axis_tdata  <= '0;
                        c_m_axis_tuser  <= '0;
                        c_m_axis_tkeep  <= '0;
                        c_m_axis_tlast  <= 1'b0;
                        pkt_done        <= 1'b1;
                    end
                end

                default: begin
                    state_reg       <= IDLE;
                    req_ready       <= 1'b1;
                    c_m_axis_tvalid <= 1'b0;
                    c_m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_cfg_pkt_gen.sv
// ---------------------------------------------------------------------------
// tb_ctrl_cfg_pkt_gen
//
// Directed bench for ctrl_cfg_pkt_gen.  A packet-level model turns each
// accepted request into a queue of expected beats; a single negedge process
// compares the DUT outputs against the model every cycle and advances the
// model using the inputs that the next rising edge will sample.  Directed
// sections add literal checks on the captured beats.
// Inputs are driven 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ctrl_cfg_pkt_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [4:0]   req_stage = '0;
    logic [2:0]   req_unit = '0;
    logic [3:0]   req_sub_unit = '0;
    logic         req_type = 1'b0;
    logic [7:0]   req_index = '0;
    logic [256:0] req_data = '0;
    logic [255:0] tdata;
    logic [127:0] tuser;
    logic [31:0]  tkeep;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic         pkt_done;

    logic         bp_mode = 1'b0;
    logic         tready_force = 1'b1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ctrl_cfg_pkt_gen dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_stage       (req_stage),
        .req_unit        (req_unit),
        .req_sub_unit    (req_sub_unit),
        .req_type        (req_type),
        .req_index       (req_index),
        .req_data        (req_data),
        .c_m_axis_tdata  (tdata),
        .c_m_axis_tuser  (tuser),
        .c_m_axis_tkeep  (tkeep),
        .c_m_axis_tvalid (tvalid),
        .c_m_axis_tready (tready),
        .c_m_axis_tlast  (tlast),
        .pkt_done        (pkt_done)
    );

    // tready: either a fixed level or a 50% random pattern.
    initial tready = 1'b1;
    always @(posedge clk) begin
        #1;
        tready = bp_mode ? 1'($urandom_range(0, 1)) : tready_force;
    end

    task automatic check(input string name, input logic [255:0] got,
                         input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Packet model
    // ------------------------------------------------------------------
    typedef struct {
        logic [255:0] data;
        logic [127:0] user;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    beat_t cap_q[$];
    logic  exp_done = 1'b0;

    function automatic logic [255:0] bswap(input logic [255:0] s);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = s[248-8*k +: 8];
        return r;
    endfunction

    function automatic void build_pkt(input logic [4:0] st, input logic [2:0] un,
                                      input logic [3:0] su, input logic ty,
                                      input logic [7:0] ix, input logic [256:0] d);
        beat_t b;
        logic [255:0] s;
        b.user = ty ? 128'd128 : 128'd96;
        b.last = 1'b0;
        b.data = 256'h0;
        exp_q.push_back(b);
        b.data          = 256'h0;
        b.data[79:64]   = 16'hF2F1;
        b.data[119:112] = {st, un};
        b.data[123:120] = {3'b000, ty};
        b.data[127:124] = su;
        b.data[135:128] = ix;
        exp_q.push_back(b);
        if (!ty) begin
            s = 256'h0;
            s[255:188] = d[67:0];
            b.data = bswap(s);
            b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            b.data = bswap(d[256:1]);
            exp_q.push_back(b);
            s = 256'h0;
            s[255] = d[0];
            b.data = bswap(s);
            b.last = 1'b1;
            exp_q.push_back(b);
        end
    endfunction

    // Compare, then advance the model to what the next edge produces.
    always @(negedge clk) begin
        check("tvalid",    {255'h0, tvalid},    {255'h0, exp_q.size() != 0});
        check("req_ready", {255'h0, req_ready}, {255'h0, exp_q.size() == 0});
        check("pkt_done",  {255'h0, pkt_done},  {255'h0, exp_done});
        if (exp_q.size() != 0) begin
            check("tdata", tdata, exp_q[0].data);
            check("tuser", {128'h0, tuser}, {128'h0, exp_q[0].user});
            check("tkeep", {224'h0, tkeep}, {224'h0, 32'hFFFF_FFFF});
            check("tlast", {255'h0, tlast}, {255'h0, exp_q[0].last});
        end

        if (rst) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (exp_q.size() != 0) begin
                if (tready) begin
                    cap_q.push_back(exp_q[0]);
                    cap_q[cap_q.size()-1].data = tdata;
                    cap_q[cap_q.size()-1].user = tuser;
                    cap_q[cap_q.size()-1].last = tlast;
                    exp_done = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
            end else if (req_valid) begin
                build_pkt(req_stage, req_unit, req_sub_unit, req_type,
                          req_index, req_data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_req(input logic [4:0] st, input logic [2:0] un,
                             input logic [3:0] su, input logic ty,
                             input logic [7:0] ix, input logic [256:0] d);
        req_valid    = 1'b1;
        req_stage    = st;
        req_unit     = un;
        req_sub_unit = su;
        req_type     = ty;
        req_index    = ix;
        req_data     = d;
    endtask

    // Hold the request until accepted, then scramble the inputs so the
    // packet in flight must come from the latched copy.
    task automatic send_req(input logic [4:0] st, input logic [2:0] un,
                            input logic [3:0] su, input logic ty,
                            input logic [7:0] ix, input logic [256:0] d);
        int n = 0;
        @(posedge clk); #1;
        drive_req(st, un, su, ty, ix, d);
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        check("accept_timeout", {255'h0, req_ready}, {255'h0, 1'b1});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_stage = ~st;
        req_index = ~ix;
        req_data  = ~d;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pkt_done && n < 300);
        check("done_timeout", {255'h0, pkt_done}, {255'h0, 1'b1});
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [256:0] mask_d;
    logic [256:0] rnd_d;

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid",   {255'h0, tvalid},    256'h0);
        check("rst_ready",    {255'h0, req_ready}, 256'h1);
        check("rst_tdata",    tdata,               256'h0);
        check("rst_tuser",    {128'h0, tuser},     256'h0);
        check("rst_tkeep",    {224'h0, tkeep},     256'h0);
        check("rst_pkt_done", {255'h0, pkt_done},  256'h0);

        // Offset write
        cap_q.delete();
        send_req(5'd2, 3'd1, 4'd0, 1'b0, 8'd5, 257'hA_BCDE_F012_3456_789A);
        wait_done();
        check("off_beats", cap_q.size(), 256'd3);
        if (cap_q.size() == 3) begin
            check("off_b0",      cap_q[0].data, 256'h0);
            check("off_b1_id",   {232'h0, cap_q[1].data[135:112]}, {232'h0, 24'h05_0_0_11});
            check("off_b1_f2f1", {240'h0, cap_q[1].data[79:64]},   {240'h0, 16'hF2F1});
            check("off_b2",      cap_q[2].data, {184'h0, 72'hA0_89_67_45_23_01_EF_CD_AB});
            check("off_len",     {240'h0, cap_q[2].user[15:0]}, 256'd96);
            check("off_lasts",   {253'h0, cap_q[0].last, cap_q[1].last, cap_q[2].last},
                                 256'b001);
        end

        // Mask write
        mask_d = {1'b1, 248'h0, 8'h03};
        cap_q.delete();
        send_req(5'd0, 3'd1, 4'd3, 1'b1, 8'd31, mask_d);
        wait_done();
        check("mask_beats", cap_q.size(), 256'd4);
        if (cap_q.size() == 4) begin
            check("mask_b1_ts", {248'h0, cap_q[1].data[127:120]}, {248'h0, 8'h31});
            check("mask_b1_ix", {248'h0, cap_q[1].data[135:128]}, {248'h0, 8'h1F});
            check("mask_b2",    cap_q[2].data, {8'h01, 240'h0, 8'h80});
            check("mask_b3",    cap_q[3].data, 256'h80);
            check("mask_len",   {240'h0, cap_q[3].user[15:0]}, 256'd128);
            check("mask_lasts", {252'h0, cap_q[0].last, cap_q[1].last,
                                 cap_q[2].last, cap_q[3].last}, 256'b0001);
        end

        // Backpressure on a mask write
        rnd_d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, 1'b1};
        bp_mode = 1'b1;
        cap_q.delete();
        send_req(5'd7, 3'd1, 4'd9, 1'b1, 8'hC4, rnd_d);
        wait_done();
        bp_mode = 1'b0;
        check("bp_beats", cap_q.size(), 256'd4);
        if (cap_q.size() == 4)
            check("bp_lasts", {252'h0, cap_q[0].last, cap_q[1].last,
                               cap_q[2].last, cap_q[3].last}, 256'b0001);

        // Reset during beat 1
        cap_q.delete();
        send_req(5'd3, 3'd1, 4'd2, 1'b1, 8'h10, rnd_d);
        for (int n = 0; n < 50 && cap_q.size() < 1; n++) @(negedge clk);
        check("rst_mid_b0", cap_q.size(), 256'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_tvalid", {255'h0, tvalid},    256'h0);
        check("rst_mid_ready",  {255'h0, req_ready}, 256'h1);
        cap_q.delete();
        send_req(5'd4, 3'd1, 4'd1, 1'b0, 8'h22, 257'h1_2345_6789_ABCD_EF01);
        wait_done();
        check("post_rst_beats", cap_q.size(), 256'd3);

        // Back-to-back: request held valid, fields swapped after acceptance
        cap_q.delete();
        @(posedge clk); #1;
        drive_req(5'd1, 3'd1, 4'd0, 1'b0, 8'h01, 257'h0_1111_2222_3333_4444);
        @(negedge clk);
        @(posedge clk); #1;
        drive_req(5'd1, 3'd1, 4'd0, 1'b1, 8'h02, rnd_d);
        wait_done();
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_done();
        check("b2b_beats", cap_q.size(), 256'd7);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_cfg_pkt_gen.md
# ctrl_cfg_pkt_gen

Control-path packet generator that builds the 256-bit AXI-Stream configuration packets consumed by the RMT stage key-extract units (and any unit using the same config format). It turns one write request (target stage/unit/sub-unit, table type, index, entry payload) into a 3-beat key-offset packet or a 4-beat key-mask packet. It sits at the head of the control daisy chain, upstream of stage 0's `c_s_axis_*` inputs.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 256: stream width; only 256 is supported.
- `C_S_AXIS_TUSER_WIDTH`, 128: tuser width.
- `KEY_LEN`, 257: mask entry width.
- `KEY_OFF`, 68: offset entry width.
- `HDR_BEAT0`, 256'h0: constant tdata of beat 0 (outer header).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: write request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_stage` in 5: target stage ID (`mod_id[7:3]`).
- `req_unit` in 3: target unit ID (`mod_id[2:0]`; key extractor = 1).
- `req_sub_unit` in 4: target sub-unit ID.
- `req_type` in 1: 0 = key-offset entry, 1 = key-mask entry.
- `req_index` in 8: table index.
- `req_data` in KEY_LEN: entry payload; offset uses `req_data[KEY_OFF-1:0]`.
- `c_m_axis_tdata` out 256, `c_m_axis_tuser` out 128, `c_m_axis_tkeep` out 32, `c_m_axis_tvalid` out 1, `c_m_axis_tlast` out 1: config stream master.
- `c_m_axis_tready` in 1: downstream ready.
- `pkt_done` out 1: one-cycle pulse when the last beat is accepted.

## Operation
- Define bswap(S): tdata byte k = S byte 31-k (tdata[8k+:8] = S[248-8k+:8]).
- States: IDLE, B0, B1, B2, B3.
- IDLE: `req_ready`=1; on handshake latch all req fields into registers, go B0. `req_ready`=0 in every other state.
- B0: tdata = `HDR_BEAT0`, tlast=0.
- B1 (control beat): tdata[79:64]=16'hF2F1, tdata[119:112]={stage,unit}, tdata[123:120]={3'b0,type}, tdata[127:124]=sub_unit, tdata[135:128]=index; all other bits 0; tlast=0.
- B2 offset (type 0): tdata = bswap(S), S[255:188]=data[67:0], S[187:0]=0; tlast=1; then IDLE.
- B2 mask (type 1): tdata = bswap(data[256:1]); tlast=0; go B3.
- B3 (mask only): tdata = bswap(S), S[255]=data[0], rest 0 (i.e. tdata[7]=data[0]); tlast=1; then IDLE.
- Every beat: tkeep = 32'hFFFFFFFF; tuser[15:0] = packet byte length (96 offset, 128 mask), tuser[127:16]=0.
- Beat advances only on `tvalid && tready`; state, tdata, tuser, tlast held stable while `tvalid && !tready`.
- `pkt_done` pulses in the cycle after the final-beat handshake (registered).
- Request fields are sampled only at acceptance; later changes to inputs do not affect the packet in flight.

## Timing
- All outputs registered. Reset values: `c_m_axis_tvalid`=0, tdata/tuser/tkeep/tlast=0, `pkt_done`=0, `req_ready`=1 (state IDLE).
- Request accepted at edge N -> beat 0 valid from cycle N+1.
- With tready held high: offset packet occupies cycles N+1..N+3, mask N+1..N+4; `req_ready` high again the cycle after tlast handshake; minimum gap between packets one idle cycle (tvalid=0).
- tvalid stays high continuously across beats of one packet when tready is high; never deasserted mid-packet except by reset.
- `rst` mid-packet: tvalid drops to 0 next cycle, packet truncated, state IDLE, latched request discarded; downstream flush relies on later tlast.
- `req_valid` during a packet: ignored (no accept) until IDLE.

## Test plan
- Offset write: stage 2, unit 1, sub 0, type 0, index 5, data[67:0]=68'hA_BCDE_F012_3456_789A, tready=1 -> 3 beats; beat1 tdata[135:112]=24'h05_0_0_11 with [79:64]=F2F1; beat2 byte-reversed payload, tlast on beat2, tuser[15:0]=96, `pkt_done` one cycle.
- Mask write: stage 0, unit 1, sub 3, index 31, data = 257'h1_FFFF...0001 -> 4 beats; beat1 tdata[127:120]=8'h31; beat2 = bswap(data[256:1]); beat3 tdata[7]=1, others 0, tlast=1, tuser[15:0]=128.
- Backpressure: random tready (50%) on mask write -> beats unchanged while stalled, exactly 4 handshakes, tlast only on 4th.
- Loopback: drive output into a key-extract instance with matching STAGE_ID/SUB_UNIT_ID -> its offset/mask RAM at index holds the requested value; mismatching stage -> packet forwarded unmodified.
- Reset mid-packet: assert `rst` during beat 1 -> tvalid 0 next cycle, `req_ready`=1, new request then produces a complete, correct packet.
- Back-to-back requests held valid -> second accepted the cycle after first `pkt_done` condition; one idle cycle between tlast and next beat 0.
